keypad_scan_reader: RTL
=======================

# keypad_scan_reader

Receive side of the one-hot column scan: consumes the rotating one-hot column strobe and the matrix row return lines. Decodes which key is pressed, debounces over whole scan frames, and reports one debounced key event per press. Sits between the column scan ring and the key-event consumer (display/controller logic), in the same clock domain as the ring.

## Interface
- `COLS`, default 5: matrix columns, equal to the scan ring width; ≥ 2.
- `ROWS`, default 4: matrix rows; ≥ 1.
- `DEBOUNCE_FRAMES`, default 4: consecutive identical frames required to accept a press or a release; ≥ 1, counter width `$clog2(DEBOUNCE_FRAMES+1)`.
- `clk` input 1: single clock. Rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `col_strobe` input COLS: one-hot column currently driven; advances one bit per cycle, LSB→MSB, then wraps to LSB.
- `row_in` input ROWS: row returns, active-high, synchronous to `clk`, valid in the same cycle as `col_strobe`.
- `key_valid` output 1: one-cycle pulse on debounced press acceptance.
- `key_code` output `$clog2(ROWS*COLS)`: code of the accepted key, `row*COLS + col`; held until the next acceptance.
- `key_held` output 1: high from acceptance until debounced release.
- `multi_key` output 1: high when the most recent complete frame saw more than one closed key.

## Operation
- Per cycle, `col_strobe` is encoded to column index c. A cycle whose strobe is not exactly one-hot (zero or multi-hot) is ignored entirely.
- Hit: a valid cycle with any `row_in` bit set. Hit code = lowest set row r × COLS + c.
- Frame accumulator records:
  - first hit code;
  - total closed keys, counting every set row bit of every valid cycle, saturating at 2.
- Frame end is a valid cycle with `col_strobe[COLS-1]`. That cycle's column is included, then the frame result is classified NONE, SINGLE(code) or MULTI, and the accumulator clears.
- Frame sync: after reset, accumulation is discarded until the first frame end is seen. The first classified frame is therefore the first complete one.
- The FSM (states IDLE, DEBOUNCE, PRESSED, RELEASE) advances only on classified frames.
  - IDLE: SINGLE(k) → cand=k, cnt=1, DEBOUNCE. If DEBOUNCE_FRAMES=1, go straight to PRESSED with acceptance.
  - DEBOUNCE:
    - SINGLE(cand) → cnt+1. When cnt reaches DEBOUNCE_FRAMES → PRESSED, pulse `key_valid`, `key_code`=cand, `key_held`=1.
    - SINGLE(other) → cand=other, cnt=1, stay.
    - NONE or MULTI → IDLE.
  - PRESSED: NONE → RELEASE, cnt=1 (if DEBOUNCE_FRAMES=1 → IDLE, `key_held`=0). SINGLE or MULTI → stay; there is no re-trigger and no new event for a different key.
  - RELEASE:
    - NONE → cnt+1. When cnt reaches DEBOUNCE_FRAMES → IDLE, `key_held`=0.
    - SINGLE or MULTI → PRESSED; `key_code` unchanged, no pulse.
- `multi_key` updates at every classified frame: 1 if MULTI, else 0.

## Timing
- Reset values: state IDLE, cnt 0, frame sync 0, accumulator clear, `key_valid`=0, `key_code`=0, `key_held`=0, `multi_key`=0.
- All outputs are registered. Changes are visible the cycle after the frame-end edge that causes them.
- Press latency: with key closed before frame start and COLS=5, `key_valid` rises 1 cycle after the DEBOUNCE_FRAMES-th frame end, i.e. 5·DEBOUNCE_FRAMES cycles after the first counted frame begins.
- `key_valid` is never high two cycles in a row.
- Reset mid-frame or mid-debounce: all state is discarded immediately, and operation resumes with frame sync.
- Ignored (non-one-hot) cycles do not end a frame and do not count keys. A frame missing columns is still classified at its frame end.

## Structure
- Package `keypad_pkg`:
  - state enum `kp_state_t` (IDLE, DEBOUNCE, PRESSED, RELEASE);
  - frame result enum `kp_frame_t` (NONE, SINGLE, MULTI).
- Sub-module `onehot_encoder` (param WIDTH): input one-hot vector → index plus `onehot_ok` (exactly one bit set). Used for `col_strobe` decoding.
- The lowest-row priority pick and the popcount-saturate logic live in the top level.

## Test plan
- COLS=5, ROWS=4, DEBOUNCE_FRAMES=4, strobe from a free-running one-hot ring.
- Clean press: hold row 2 on col 3 for 6 frames → exactly one `key_valid` pulse, `key_code`=13, `key_held`=1 after the 4th full frame end.
- Bounce: key 13 closed for 2 frames, open 1, closed 4 → single pulse, only after the final 4-frame run.
- Release: hold key 7, then open → `key_held` drops 1 cycle after the 4th consecutive NONE frame. A hit in RELEASE after 2 NONE frames returns to PRESSED with no pulse.
- Multi: keys 0 and 19 both closed → `multi_key`=1 each frame, no `key_valid`. Releasing key 19 with key 0 held → press of code 0 accepted after 4 frames.
- Reset mid-frame: assert `rst` at strobe 00100 during debounce count 3 → all outputs 0; the first frame counted is the one starting after the next 10000.
- Bad strobe: inject 00000 and 01100 cycles while key 13 is held → those cycles are ignored, and the debounce still completes on schedule.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan receiver: debounce FSM states,
// per-frame classification results and a saturating key-count adder.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } kp_state_t;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } kp_frame_t;

  // Key counts only need to distinguish none / one / more than one.
  function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= 3'd2) ? 2'd2 : sum[1:0];
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// One-hot to binary index encoder; onehot_ok is high only when exactly one
// bit of the input vector is set.
module onehot_encoder
  import keypad_pkg::*;
#(
  parameter  int WIDTH = 5,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             onehot_ok
);

  logic [1:0] ones;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx  = '0;
    ones = 2'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx = idx | IDX_W'(i);
      end
      ones = sat_add2(ones, {1'b0, vec[i]});
    end
    onehot_ok = (ones == 2'd1);
  end

endmodule

// File: rtl/keypad_scan_reader.sv
// Receive side of the one-hot column scan: accumulates row returns over each
// scan frame, classifies the frame and debounces presses/releases per frame.
module keypad_scan_reader
  import keypad_pkg::*;
#(
  parameter  int COLS            = 5,
  parameter  int ROWS            = 4,
  parameter  int DEBOUNCE_FRAMES = 4,
  localparam int CODE_W          = $clog2(ROWS * COLS),
  localparam int COL_W           = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int ROW_W           = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CNT_W           = $clog2(DEBOUNCE_FRAMES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col_strobe,
  input  logic [ROWS-1:0]   row_in,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held,
  output logic              multi_key
);

  logic [COL_W-1:0]  col_idx;
  logic              col_ok;

  onehot_encoder #(.WIDTH(COLS)) u_col_enc (
    .vec       (col_strobe),
    .idx       (col_idx),
    .onehot_ok (col_ok)
  );

  // Frame accumulator: acc_cnt != 0 doubles as "a hit has been recorded".
  logic [1:0]        acc_cnt;
  logic [CODE_W-1:0] acc_code;
  logic              synced;

  logic [ROW_W-1:0]  row_sel;
  logic [1:0]        cyc_cnt;
  logic [CODE_W-1:0] hit_code;
  logic [1:0]        nxt_cnt;
  logic [CODE_W-1:0] nxt_code;
  logic              frame_end;
  logic              frame_done;
  kp_frame_t         frame_res;

  always_comb begin
    row_sel = '0;
    cyc_cnt = 2'd0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row_in[r]) begin
        row_sel = ROW_W'(r);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      cyc_cnt = sat_add2(cyc_cnt, {1'b0, row_in[r]});
    end
    hit_code = CODE_W'(row_sel) * CODE_W'(COLS) + CODE_W'(col_idx);

    // Non-one-hot cycles contribute nothing and cannot end a frame.
    nxt_cnt    = col_ok ? sat_add2(acc_cnt, cyc_cnt) : acc_cnt;
    nxt_code   = (acc_cnt != 2'd0) ? acc_code : hit_code;
    frame_end  = col_ok & col_strobe[COLS-1];
    frame_done = frame_end & synced;

    if (nxt_cnt == 2'd0) begin
      frame_res = FR_NONE;
    end else if (nxt_cnt == 2'd1) begin
      frame_res = FR_SINGLE;
    end else begin
      frame_res = FR_MULTI;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt  <= 2'd0;
      acc_code <= '0;
      synced   <= 1'b0;
    end else if (col_ok) begin
      if (frame_end) begin
        acc_cnt  <= 2'd0;
        acc_code <= '0;
        synced   <= 1'b1;
      end else begin
        acc_cnt  <= nxt_cnt;
        acc_code <= nxt_code;
      end
    end
  end

  kp_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] cand;
  logic [CNT_W-1:0]  cnt_inc;
  logic              at_limit;

  always_comb begin
    cnt_inc  = cnt + CNT_W'(1);
    at_limit = (cnt_inc == CNT_W'(DEBOUNCE_FRAMES));
  end

  // Debounce FSM: advances only on classified frames; outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_done) begin
        multi_key <= (frame_res == FR_MULTI);
        case (state)
          IDLE: begin
            if (frame_res == FR_SINGLE) begin
              cand <= nxt_code;
              if (DEBOUNCE_FRAMES == 1) begin
                state     <= PRESSED;
                cnt       <= '0;
                key_valid <= 1'b1;
                key_code  <= nxt_code;
                key_held  <= 1'b1;
              end else begin
                state <= DEBOUNCE;
                cnt   <= CNT_W'(1);
              end
            end
          end
          DEBOUNCE: begin
            if (frame_res == FR_SINGLE) begin
              if (nxt_code == cand) begin
                if (at_limit) begin
                  state     <= PRESSED;
                  cnt       <= '0;
                  key_valid <= 1'b1;
                  key_code  <= cand;
                  key_held  <= 1'b1;
                end else begin
                  cnt <= cnt_inc;
                end
              end else begin
                cand <= nxt_code;
                cnt  <= CNT_W'(1);
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (frame_res == FR_NONE) begin
              if (DEBOUNCE_FRAMES == 1) begin
                state    <= IDLE;
                cnt      <= '0;
                key_held <= 1'b0;
              end else begin
                state <= RELEASE;
                cnt   <= CNT_W'(1);
              end
            end
          end
          RELEASE: begin
            if (frame_res == FR_NONE) begin
              if (at_limit) begin
                state    <= IDLE;
                cnt      <= '0;
                key_held <= 1'b0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
